// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: mode encoding and a round-robin first-set search
// sized for up to 16 requesters so future arbiters can reuse it.
package alu_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int MAX_CH = 16;
  localparam int IDX_W  = 4;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } rr_grant_t;

  // req bits at or above n must be zero; ptr must be below n.
  function automatic rr_grant_t rr_first(
    input logic [MAX_CH-1:0] req,
    input logic [IDX_W-1:0]  ptr,
    input logic [IDX_W:0]    n
  );
    logic [IDX_W:0] pos;
    rr_grant_t      g;
    g = '0;
    // Offsets are walked high-to-low so the requester closest to ptr is written last.
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + k[IDX_W:0];
      if (pos >= n) pos = pos - n;
      if ((k[IDX_W:0] < n) && req[pos[IDX_W-1:0]]) begin
        g.vld = 1'b1;
        g.idx = pos[IDX_W-1:0];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/alu_operand_mux_if.sv
// Operand-selector bus: control, per-channel valid/ready inputs and the registered
// output with its own valid/ready. master drives the channels, slave is the mux.
interface alu_operand_mux_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 3,
  parameter int SEL_W = 2
);

  logic                 mode;
  logic [SEL_W-1:0]     ctrl;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_ch;
  logic                 out_valid;
  logic                 out_ready;
  logic                 err_sel;

  modport master (
    output mode, ctrl, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid, err_sel
  );

  modport slave (
    input  mode, ctrl, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid, err_sel
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, with wrap.
// Zero latency; no handshake of its own.
module rr_pick #(
  parameter int NCH   = 3,
  parameter int SEL_W = 2
) (
  input  logic [NCH-1:0]   i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_gnt,
  output logic             o_gnt_vld
);
  import alu_pkg::*;

  logic [MAX_CH-1:0] w_req;
  logic [IDX_W-1:0]  w_ptr;
  rr_grant_t         w_res;

  assign w_req     = MAX_CH'(i_req);
  assign w_ptr     = IDX_W'(i_ptr);
  assign w_res     = rr_first(w_req, w_ptr, (IDX_W + 1)'(NCH));
  assign o_gnt     = SEL_W'(w_res.idx);
  assign o_gnt_vld = w_res.vld;

endmodule

// File: rtl/alu_operand_mux.sv
// Registered N-channel operand selector (fixed or round-robin), one cycle latency.
// A held output with out_ready low drops every in_ready; drain and refill overlap.
module alu_operand_mux
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 3,
  parameter int SEL_W = 2
) (
  input logic              clk,
  input logic              rst_n,
  alu_operand_mux_if.slave bus
);

  localparam logic [SEL_W:0]   NCH_L   = (SEL_W + 1)'(NCH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NCH - 1);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_ch;
  logic             r_err_sel;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_can_accept;
  logic             w_ctrl_ok;
  logic             w_fix_req;
  logic             w_rr_vld;
  logic [SEL_W-1:0] w_rr_gnt;
  logic             w_gnt_vld;
  logic [SEL_W-1:0] w_gnt;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_xfer;
  logic             w_err;

  assign w_can_accept = !r_out_valid || bus.out_ready;
  assign w_ctrl_ok    = {1'b0, bus.ctrl} < NCH_L;

  rr_pick #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .i_req     (bus.in_valid),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_rr_gnt),
    .o_gnt_vld (w_rr_vld)
  );

  // Decoded by comparison rather than indexing so an out-of-range ctrl reads as no request.
  always_comb begin
    w_fix_req = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.ctrl == SEL_W'(i)) w_fix_req = bus.in_valid[i];
    end
  end

  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    if (bus.mode == MODE_RR) begin
      w_gnt     = w_rr_gnt;
      w_gnt_vld = w_rr_vld;
    end else if (w_ctrl_ok) begin
      w_gnt     = bus.ctrl;
      w_gnt_vld = w_fix_req;
    end
  end

  always_comb begin
    bus.in_ready = '0;
    w_gnt_data   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_gnt == SEL_W'(i)) begin
        w_gnt_data      = bus.in_data[i*WIDTH +: WIDTH];
        bus.in_ready[i] = w_can_accept && w_gnt_vld;
      end
    end
  end

  assign w_xfer = w_can_accept && w_gnt_vld;
  assign w_err  = (bus.mode == MODE_FIXED) && !w_ctrl_ok && w_can_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_err_sel   <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      r_err_sel <= w_err;
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gnt_data;
        r_out_ch    <= w_gnt;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_xfer && (bus.mode == MODE_RR)) begin
        r_rr_ptr <= (w_gnt == LAST_CH) ? '0 : w_gnt + SEL_W'(1);
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.err_sel   = r_err_sel;

endmodule

// File: tb/tb_alu_operand_mux.sv
// Bench for alu_operand_mux: an 8-bit/3-channel and a 16-bit/5-channel instance
// driven in lockstep and compared against a cycle-level reference model.
module tb_alu_operand_mux;

  logic clk;
  logic rst_n;
  int   ntests = 0;
  int   nfail  = 0;

  alu_operand_mux_if #(.WIDTH(8),  .NCH(3), .SEL_W(2)) ifa ();
  alu_operand_mux_if #(.WIDTH(16), .NCH(5), .SEL_W(3)) ifb ();

  alu_operand_mux #(.WIDTH(8),  .NCH(3), .SEL_W(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  alu_operand_mux #(.WIDTH(16), .NCH(5), .SEL_W(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  logic        a_mode;
  logic [1:0]  a_ctrl;
  logic [2:0]  a_valid;
  logic [7:0]  a_dat [3];
  logic        a_ordy;
  logic        b_mode;
  logic [2:0]  b_ctrl;
  logic [4:0]  b_valid;
  logic [15:0] b_dat [5];
  logic        b_ordy;

  assign ifa.mode      = a_mode;
  assign ifa.ctrl      = a_ctrl;
  assign ifa.in_valid  = a_valid;
  assign ifa.in_data   = {a_dat[2], a_dat[1], a_dat[0]};
  assign ifa.out_ready = a_ordy;
  assign ifb.mode      = b_mode;
  assign ifb.ctrl      = b_ctrl;
  assign ifb.in_valid  = b_valid;
  assign ifb.in_data   = {b_dat[4], b_dat[3], b_dat[2], b_dat[1], b_dat[0]};
  assign ifb.out_ready = b_ordy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference state per instance (0 = A, 1 = B): expected output register and pointer.
  int ev [2];
  int ed [2];
  int ech[2];
  int eer[2];
  int ptr[2];

  function automatic int ref_grant(int nch, int mode, int ctrl, int vmask, int p);
    if (mode == 0) return (ctrl < nch && ((vmask >> ctrl) & 1) != 0) ? ctrl : -1;
    for (int k = 0; k < nch; k++) begin
      if (((vmask >> ((p + k) % nch)) & 1) != 0) return (p + k) % nch;
    end
    return -1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      ev[d] = 0; ed[d] = 0; ech[d] = 0; eer[d] = 0; ptr[d] = 0;
    end
  endtask

  task automatic model_edge(int d, bit can, int g, int mode, int ctrl, int nch, int dat);
    eer[d] = (mode == 0 && ctrl >= nch && can) ? 1 : 0;
    if (can && g >= 0) begin
      ev[d] = 1; ed[d] = dat; ech[d] = g;
      if (mode == 1) ptr[d] = (g + 1) % nch;
    end else if (can) begin
      ev[d] = 0;
    end
  endtask

  task automatic check_outs();
    check("a_out_valid", 32'(ifa.out_valid), 32'(ev[0]));
    check("a_out_data",  32'(ifa.out_data),  32'(ed[0]));
    check("a_out_ch",    32'(ifa.out_ch),    32'(ech[0]));
    check("a_err_sel",   32'(ifa.err_sel),   32'(eer[0]));
    check("b_out_valid", 32'(ifb.out_valid), 32'(ev[1]));
    check("b_out_data",  32'(ifb.out_data),  32'(ed[1]));
    check("b_out_ch",    32'(ifb.out_ch),    32'(ech[1]));
    check("b_err_sel",   32'(ifb.err_sel),   32'(eer[1]));
  endtask

  // Entered one time unit after a rising edge with inputs already applied.
  task automatic tick();
    int ga, gb, da, db;
    bit ca, cb;
    #1;
    ca = (ev[0] == 0) || a_ordy;
    cb = (ev[1] == 0) || b_ordy;
    ga = ref_grant(3, int'(a_mode), int'(a_ctrl), int'(a_valid), ptr[0]);
    gb = ref_grant(5, int'(b_mode), int'(b_ctrl), int'(b_valid), ptr[1]);
    check("a_in_ready", 32'(ifa.in_ready), (ca && ga >= 0) ? (32'd1 << ga) : 32'd0);
    check("b_in_ready", 32'(ifb.in_ready), (cb && gb >= 0) ? (32'd1 << gb) : 32'd0);
    da = (ga >= 0) ? int'(a_dat[ga]) : 0;
    db = (gb >= 0) ? int'(b_dat[gb]) : 0;
    @(posedge clk);
    model_edge(0, ca, ga, int'(a_mode), int'(a_ctrl), 3, da);
    model_edge(1, cb, gb, int'(b_mode), int'(b_ctrl), 5, db);
    #1;
    check_outs();
  endtask

  initial begin
    rst_n   = 1'b0;
    a_mode  = 1'b0; a_ctrl = '0; a_valid = '0; a_ordy = 1'b1;
    a_dat   = '{8'd5, 8'd10, 8'd15};
    b_mode  = 1'b0; b_ctrl = '0; b_valid = '0; b_ordy = 1'b1;
    b_dat   = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    reset_model();
    #1;
    check_outs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fixed select walks channels 0,1,2.
    a_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      a_ctrl = 2'(i);
      tick();
    end

    // Out-of-range select held two cycles, then a legal select.
    a_ctrl = 2'd3;
    tick();
    tick();
    a_ctrl = 2'd1;
    tick();
    check("a_holds_10", 32'(ifa.out_data), 32'd10);

    // Stall with changing inputs, then release with a word waiting.
    a_ordy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_ctrl   = 2'(i);
      a_dat[0] = 8'($urandom);
      a_dat[2] = 8'($urandom);
      tick();
    end
    a_ordy = 1'b1;
    a_ctrl = 2'd2;
    tick();

    // Round-robin, all valid then only channels 1 and 2 from pointer 0.
    a_dat  = '{8'd5, 8'd10, 8'd15};
    a_mode = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    a_valid = 3'b100;
    tick();
    a_valid = 3'b110;
    for (int i = 0; i < 4; i++) tick();

    // Signed extremes on A in fixed mode; B round-robins with wrap.
    a_mode  = 1'b0;
    a_valid = 3'b111;
    a_dat   = '{8'h80, 8'hFF, 8'h7F};
    b_mode  = 1'b1;
    b_valid = 5'h1F;
    b_dat   = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0001, 16'($urandom)};
    for (int i = 0; i < 7; i++) begin
      a_ctrl = 2'(i % 3);
      tick();
    end

    for (int n = 0; n < 400; n++) begin
      a_mode  = 1'($urandom_range(0, 1));
      a_ctrl  = 2'($urandom);
      a_valid = 3'($urandom);
      a_ordy  = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 3; k++) a_dat[k] = 8'($urandom);
      b_mode  = 1'($urandom_range(0, 1));
      b_ctrl  = 3'($urandom);
      b_valid = 5'($urandom);
      b_ordy  = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 5; k++) b_dat[k] = 16'($urandom);
      tick();
    end

    // Reset asserted between edges while both outputs are stalled.
    a_mode = 1'b0; a_ctrl = '0; a_valid = 3'b111;  a_ordy = 1'b0;
    b_mode = 1'b0; b_ctrl = '0; b_valid = 5'h1F;   b_ordy = 1'b0;
    tick();
    tick();
    check("a_stalled_valid", 32'(ifa.out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    reset_model();
    check_outs();
    #20;
    rst_n  = 1'b1;
    a_mode = 1'b1; a_ordy = 1'b1;
    b_mode = 1'b1; b_ordy = 1'b1;
    tick();
    check("a_rr_first_after_reset", 32'(ifa.out_ch), 32'd0);
    check("b_rr_first_after_reset", 32'(ifb.out_ch), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/alu_operand_mux.md
Name: alu_operand_mux

Overview:
- Parametrised, registered N-channel signed operand selector feeding the ALU datapath; successor to the 3-input combinational ALU mux.
- Each channel has a valid/ready handshake; the output is one register stage with valid/ready.
- Two selection modes: fixed (explicit ctrl select) or round-robin among valid channels.
- Flags out-of-range selects instead of producing undefined data.

Parameters:
- WIDTH, 8, data width of each channel and of the output (two's complement, passed through unmodified).
- NCH, 3, number of input channels (2..16).
- SEL_W, 2, width of ctrl and out_ch; must satisfy 2^SEL_W >= NCH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  0 = fixed select via ctrl, 1 = round-robin
- ctrl  in  SEL_W  channel select in fixed mode; ignored in round-robin
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NCH  per-channel data valid
- in_ready  out  NCH  per-channel accept; at most one bit high per cycle
- out_data  out  WIDTH  registered selected operand
- out_ch  out  SEL_W  index of the channel that supplied out_data
- out_valid  out  1  out_data/out_ch valid
- out_ready  in  1  downstream accept
- err_sel  out  1  one-cycle pulse: fixed-mode ctrl >= NCH

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, err_sel=0, rr_ptr=0.
- Reset mid-operation discards held data. No transfer occurs on the first edge after deassertion unless inputs are valid then.
- can_accept = !out_valid | out_ready.
- Grant computation (combinational, one grant max):
  - fixed: grant = ctrl when ctrl < NCH and in_valid[ctrl]; otherwise no grant.
  - round-robin: grant = the first i with in_valid[i], searching rr_ptr, rr_ptr+1, ... with wrap modulo NCH; no grant if in_valid == 0.
- Handshake and transfer:
  - in_ready[i] = can_accept & grant_valid & (grant == i). in_ready depends combinationally on in_valid, mode, ctrl and out_ready. No input may depend combinationally on in_ready.
  - Transfer on channel i when in_valid[i] & in_ready[i]. At the clock edge: out_data <= channel i data, out_ch <= i, out_valid <= 1.
  - Latency: one cycle from the accepting edge to out_valid.
- Output register update:
  - out_valid & out_ready with no new transfer: out_valid <= 0; out_data and out_ch hold their last values.
  - Simultaneous drain and new transfer in the same cycle: out_valid stays 1 and the data is replaced. Full throughput is one word per cycle.
  - out_valid & !out_ready: out_data and out_ch are stable; all in_ready = 0.
- rr_ptr:
  - Updates only on a round-robin-mode transfer: rr_ptr <= (grant == NCH-1) ? 0 : grant + 1.
  - Unchanged by fixed-mode transfers and by mode switches. A mode change takes effect on the same cycle's grant.
- err_sel:
  - Registered, high for exactly one cycle after any cycle with mode=0 & ctrl >= NCH & can_accept. It pulses every such cycle while the condition persists.
  - No data moves for that select.
- Arithmetic: none; bit-exact passthrough, so sign is preserved (8'h80 stays 8'h80).

Decomposition:
- Shared package alu_pkg holds:
  - the mode encoding constants MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - a function computing the round-robin first-set index from a request vector and pointer, reused by future arbiters.
- One natural sub-module, rr_pick: combinational request vector + pointer -> grant index + grant_valid.
- Top level holds the fixed/rr grant mux, handshake logic, output register, rr_ptr and err_sel.

Test Plan:
- Fixed mode: channels = 5, 10, 15, all valid, out_ready=1; ctrl = 0, 1, 2 on successive cycles -> out_data 5, 10, 15 with out_ch 0, 1, 2, each one cycle after its ctrl. in_ready is one-hot, matching ctrl.
- Fixed mode ctrl=3, NCH=3 -> in_ready=000, out_valid falls after drain, err_sel=1 for one cycle per cycle held. Then ctrl=1 -> out_data=10, err_sel=0.
- Backpressure: out holds 10, out_ready=0 for 4 cycles while inputs change -> out_data=10 and out_valid=1 stable, in_ready=000. Then out_ready=1 -> next word accepted the same cycle, out_valid never drops.
- Round-robin, all valid, rr_ptr=0 -> out_ch sequence 0, 1, 2, 0, 1 at one word per cycle. With only ch1 and ch2 valid from rr_ptr=0 -> 1, 2, 1, 2.
- Signed passthrough: channel data -128 (8'h80), -1 (8'hFF) and 127 -> out_data bit-identical. Repeat at WIDTH=16, NCH=5, SEL_W=3 with round-robin -> order 0..4 and wrap.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst_n=0 asynchronously between edges -> out_valid, out_data and out_ch go to 0 immediately. rr_ptr is back at 0, so the first round-robin grant after release goes to channel 0.
